// File: rtl/banked_ram.sv
// =============================================================================
// Module      : banked_ram
// Description : Byte-addressed data RAM for the f8 data-memory window. It has
//               one read port and one write port, each LANES bytes wide at any
//               byte alignment, built from LANES interleaved 8-bit banks.
//               Optional zero-fill after reset: define BANKED_RAM_CLEAR_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module banked_ram #(
    parameter int          ADDRBITS = 10,
    parameter logic [15:0] RAMBASE  = 16'h3c00,
    parameter int          LANES    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          dread_addr,
    output logic [8*LANES-1:0]   dread_data,
    output logic                 dread_oob,
    input  logic [15:0]          dwrite_addr,
    input  logic [8*LANES-1:0]   dwrite_data,
    input  logic [LANES-1:0]     dwrite_en,
    output logic                 busy
);

    localparam int C_LANE_BITS = $clog2(LANES);
    localparam int C_ROW_BITS  = ADDRBITS - C_LANE_BITS;
    localparam int C_ROWS      = 1 << C_ROW_BITS;

    logic [15:0]            w_rd_off [LANES];
    logic [15:0]            w_wr_off [LANES];
    logic [LANES-1:0]       w_rd_in;
    logic [LANES-1:0]       w_wr_in;
    logic [C_LANE_BITS-1:0] w_rd_rot;
    logic [C_LANE_BITS-1:0] w_wr_rot;
    logic [7:0]             w_bank_q [LANES];
    logic                   w_busy;
    logic [C_ROW_BITS-1:0]  w_fill_row;

    logic [C_LANE_BITS-1:0] r_rot;
    logic [LANES-1:0]       r_lane_ok;

    // Window-relative offset of every lane; an offset that wraps below the
    // base lands far above the window and is therefore out of range.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_rd_off[i] = dread_addr + 16'(i) - RAMBASE;
            w_wr_off[i] = dwrite_addr + 16'(i) - RAMBASE;
            w_rd_in[i]  = (w_rd_off[i] >> ADDRBITS) == 16'd0;
            w_wr_in[i]  = (w_wr_off[i] >> ADDRBITS) == 16'd0;
        end
    end

    assign w_rd_rot = w_rd_off[0][C_LANE_BITS-1:0];
    assign w_wr_rot = w_wr_off[0][C_LANE_BITS-1:0];

    generate
        for (genvar b = 0; b < LANES; b++) begin : g_bank
            logic [C_LANE_BITS-1:0] w_rl;
            logic [C_LANE_BITS-1:0] w_wl;
            logic [C_ROW_BITS-1:0]  w_rrow;
            logic [C_ROW_BITS-1:0]  w_ext_row;
            logic [C_ROW_BITS-1:0]  w_wrow;
            logic [7:0]             w_ext_data;
            logic [7:0]             w_wdata;
            logic                   w_ext_we;
            logic                   w_we;
            logic [7:0]             r_mem [C_ROWS];
            logic [7:0]             r_q;

            // Lane that lands on this bank for the current alignment.
            assign w_rl       = C_LANE_BITS'(b) - w_rd_rot;
            assign w_wl       = C_LANE_BITS'(b) - w_wr_rot;
            assign w_rrow     = w_rd_off[w_rl][ADDRBITS-1:C_LANE_BITS];
            assign w_ext_row  = w_wr_off[w_wl][ADDRBITS-1:C_LANE_BITS];
            assign w_ext_data = dwrite_data[{w_wl, 3'b000} +: 8];
            assign w_ext_we   = dwrite_en[w_wl] & w_wr_in[w_wl];

            assign w_we    = w_busy | w_ext_we;
            assign w_wrow  = w_busy ? w_fill_row : w_ext_row;
            assign w_wdata = w_busy ? 8'h00 : w_ext_data;

            // Explicit forwarding so a same-edge write is seen by the read.
            always_ff @(posedge clk) begin
                if (w_we) begin
                    r_mem[w_wrow] <= w_wdata;
                end
                r_q <= (w_we && (w_wrow == w_rrow)) ? w_wdata : r_mem[w_rrow];
            end

            assign w_bank_q[b] = r_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rot     <= '0;
            r_lane_ok <= '0;
            dread_oob <= 1'b0;
        end else begin
            r_rot     <= w_rd_rot;
            r_lane_ok <= w_busy ? '0 : w_rd_in;
            dread_oob <= ~w_busy & ~(&w_rd_in);
        end
    end

    // Un-rotate bank outputs back into lane order.
    always_comb begin
        dread_data = '0;
        for (int i = 0; i < LANES; i++) begin
            dread_data[8*i +: 8] = r_lane_ok[i] ? w_bank_q[r_rot + C_LANE_BITS'(i)] : 8'h00;
        end
    end

`ifdef BANKED_RAM_CLEAR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } fill_state_t;

    fill_state_t           r_state;
    logic [C_ROW_BITS-1:0] r_fill_row;
    logic                  r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_CLEAR;
            r_fill_row <= '0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_fill_row <= r_fill_row + C_ROW_BITS'(1);
                    if (r_fill_row == C_ROW_BITS'(C_ROWS - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_busy     = r_busy;
    assign w_fill_row = r_fill_row;
    assign busy       = r_busy;
`else
    assign w_busy     = 1'b0;
    assign w_fill_row = '0;
    assign busy       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_banked_ram.sv
// =============================================================================
// Module      : tb_banked_ram
// Description : Randomized and directed checks of banked_ram (LANES=2 and 4)
//               against a byte-array reference model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_banked_ram;

    localparam logic [15:0] BASE = 16'h3c00;
`ifdef BANKED_RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ra = '0;
    logic [15:0] wa = '0;
    logic [31:0] wd = '0;
    logic [3:0]  we = '0;

    logic [15:0] d2_rdata;
    logic        d2_oob;
    logic        d2_busy;
    logic [31:0] d4_rdata;
    logic        d4_oob;
    logic        d4_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mm [2][1024];
    bit         kk [2][1024];
    int         fill [2];

    always #5 clk = ~clk;

    banked_ram #(.ADDRBITS(10), .RAMBASE(16'h3c00), .LANES(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .dread_addr(ra), .dread_data(d2_rdata), .dread_oob(d2_oob),
        .dwrite_addr(wa), .dwrite_data(wd[15:0]), .dwrite_en(we[1:0]),
        .busy(d2_busy)
    );

    banked_ram #(.ADDRBITS(10), .RAMBASE(16'h3c00), .LANES(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .dread_addr(ra), .dread_data(d4_rdata), .dread_oob(d4_oob),
        .dwrite_addr(wa), .dwrite_data(wd), .dwrite_en(we),
        .busy(d4_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: apply the edge's writes first, then read, which gives
    // same-edge forwarding for free.
    task automatic mdl(input int k, input logic [15:0] raddr, input logic [15:0] waddr,
                       input logic [31:0] wdat, input logic [3:0] wen,
                       output logic [31:0] ed, output logic [31:0] mask,
                       output logic eoob, output logic ebusy);
        logic [15:0] o;
        int          n;
        bit          bz;
        n  = (k == 0) ? 2 : 4;
        bz = fill[k] > 0;
        for (int i = 0; i < n; i++) begin
            o = waddr + 16'(i) - BASE;
            if (!bz && wen[i] && o < 16'd1024) begin
                mm[k][o[9:0]] = wdat[8*i +: 8];
                kk[k][o[9:0]] = 1'b1;
            end
        end
        ed = '0; mask = '0; eoob = 1'b0;
        for (int i = 0; i < n; i++) begin
            o = raddr + 16'(i) - BASE;
            if (bz) begin
                mask[8*i +: 8] = 8'hff;
            end else if (o < 16'd1024) begin
                ed[8*i +: 8]   = mm[k][o[9:0]];
                mask[8*i +: 8] = kk[k][o[9:0]] ? 8'hff : 8'h00;
            end else begin
                mask[8*i +: 8] = 8'hff;
                eoob = 1'b1;
            end
        end
        if (bz) fill[k]--;
        ebusy = fill[k] > 0;
    endtask

    task automatic step(input logic [15:0] r, input logic [15:0] w, input logic [31:0] d,
                        input logic [3:0] e);
        logic [31:0] e0, m0, e1, m1;
        logic        o0, o1, b0, b1;
        ra = r; wa = w; wd = d; we = e;
        @(posedge clk);
        mdl(0, r, w, d, {2'b00, e[1:0]}, e0, m0, o0, b0);
        mdl(1, r, w, d, e, e1, m1, o1, b1);
        @(negedge clk);
        check("rd2", {16'h0, d2_rdata} & m0, e0 & m0);
        check("oob2", {31'h0, d2_oob}, {31'h0, o0});
        check("busy2", {31'h0, d2_busy}, {31'h0, b0});
        check("rd4", d4_rdata & m1, e1 & m1);
        check("oob4", {31'h0, d4_oob}, {31'h0, o1});
        check("busy4", {31'h0, d4_busy}, {31'h0, b1});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ra = '0; wa = '0; wd = '0; we = '0;
        fill[0] = CLR ? 512 : 0;
        fill[1] = CLR ? 256 : 0;
        if (CLR) begin
            for (int k = 0; k < 2; k++)
                for (int a = 0; a < 1024; a++) begin
                    mm[k][a] = 8'h00;
                    kk[k][a] = 1'b1;
                end
        end
        @(posedge clk);
        @(negedge clk);
        check("rst_rd2", {16'h0, d2_rdata}, 32'h0);
        check("rst_oob2", {31'h0, d2_oob}, 32'h0);
        check("rst_busy2", {31'h0, d2_busy}, {31'h0, CLR});
        check("rst_rd4", d4_rdata, 32'h0);
        check("rst_oob4", {31'h0, d4_oob}, 32'h0);
        check("rst_busy4", {31'h0, d4_busy}, {31'h0, CLR});
        reset = 1'b0;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom % 8)
            0: return 16'hffff;
            1: return BASE - 16'($urandom % 4);
            2: return 16'h3ffc + 16'($urandom % 4);
            default: return BASE + 16'($urandom % 48);
        endcase
    endfunction

`ifdef BANKED_RAM_CLEAR_EN
    task automatic count_fill(input logic [15:0] poke_addr);
        int c2 = 0;
        int c4 = 0;
        for (int j = 0; j < 2000 && (d2_busy || d4_busy); j++) begin
            if (d2_busy) c2++;
            if (d4_busy) c4++;
            step(16'h3c30, poke_addr, 32'hdeadbeef, (j == 5) ? 4'hf : 4'h0);
        end
        check("fill_len2", 32'(c2), 32'd512);
        check("fill_len4", 32'(c4), 32'd256);
    endtask
`endif

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 1024; a++) kk[k][a] = 1'b0;
        fill[0] = 0;
        fill[1] = 0;
        do_reset();

`ifdef BANKED_RAM_CLEAR_EN
        count_fill(16'h3c30);
        step(16'h3c30, 16'h0, 32'h0, 4'h0);
        check("fill_drop", d4_rdata, 32'h0);
`endif

        step(16'h0, 16'h3c00, 32'h00005a5a, 4'b0011);
        step(16'h0, 16'h3c01, 32'h0000beef, 4'b0011);
        step(16'h3c01, 16'h0, 32'h0, 4'h0);
        check("beef", {16'h0, d2_rdata}, 32'h0000beef);
        step(16'h3c02, 16'h0, 32'h0, 4'h0);
        check("beef_hi", {24'h0, d2_rdata[7:0]}, 32'h000000be);

        step(16'h0, 16'h3fff, 32'h00001234, 4'b0011);
        step(16'h3fff, 16'h0, 32'h0, 4'h0);
        check("top_rd", {16'h0, d2_rdata}, 32'h00000034);
        check("top_oob", {31'h0, d2_oob}, 32'h1);
        step(16'h3c00, 16'h0, 32'h0, 4'h0);
        check("wrap_drop", {16'h0, d2_rdata}, 32'h0000ef5a);

        step(16'h0, 16'h3c10, 32'h0000aa55, 4'b0011);
        step(16'h0, 16'h3c10, 32'h00000000, 4'b0010);
        step(16'h3c10, 16'h0, 32'h0, 4'h0);
        check("byte_en", {16'h0, d2_rdata}, 32'h00000055);

        step(16'h3c20, 16'h3c20, 32'h00007788, 4'b0011);
        check("fwd", {16'h0, d2_rdata}, 32'h00007788);

        step(16'h0, 16'h3c03, 32'h44332211, 4'hf);
        step(16'h3c02, 16'h0, 32'h0, 4'h0);
        check("l4_rd", d4_rdata, 32'h332211be);
        check("l4_oob", {31'h0, d4_oob}, 32'h0);

        for (int j = 0; j < 400; j++)
            step(pick(), pick(), $urandom, 4'($urandom));

`ifdef BANKED_RAM_CLEAR_EN
        do_reset();
        for (int j = 0; j < 100; j++)
            step(pick(), pick(), $urandom, 4'($urandom));
        do_reset();
        count_fill(16'h3c40);
`endif

        for (int a = 0; a < 1024; a += 2)
            step(BASE + 16'(a), 16'h0, 32'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
